pspin_dma_rd_desc_arb: RTL and testbench

//  Shares the single Corundum DMA read-descriptor channel between PORTS requesters
//  (e.g. the hostmem read adapter and the PsPIN command unit).
//  - Round-robin arbitration of incoming descriptors.
//  - Each descriptor gets a slot-table tag; read status is routed back to the owning port.
//  - Placed between requesters and the DMA interface's read descriptor/status ports.

---
 rtl/pspin_dma_rd_desc_arb_pkg.sv | 26 ++
 rtl/pspin_dma_rd_desc_arb_if.sv | 66 ++++++
 rtl/pspin_dma_rd_desc_arb_rr_arb.sv | 45 ++++
 rtl/pspin_dma_rd_desc_arb.sv | 144 ++++++++++++++
 tb/tb_pspin_dma_rd_desc_arb.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pspin_dma_rd_desc_arb_pkg.sv
// Shared types for the DMA read-descriptor arbiter: slot-table entry and
// the DMA completion error codes.
package pspin_dma_pkg;

    localparam int SLOT_PORT_W = 8;
    localparam int SLOT_TAG_W  = 32;
    localparam int DMA_ERR_W   = 4;

    typedef enum logic [DMA_ERR_W-1:0] {
        DMA_ERR_NONE    = 4'h0,
        DMA_ERR_TIMEOUT = 4'h1,
        DMA_ERR_PARITY  = 4'h2,
        DMA_ERR_ECRC    = 4'h3,
        DMA_ERR_UR      = 4'h4,
        DMA_ERR_CA      = 4'h5
    } dma_err_e;

    // Fields are sized for the widest supported configuration; narrower
    // instances zero-extend on write and slice on read.
    typedef struct packed {
        logic                   valid;
        logic [SLOT_PORT_W-1:0] port;
        logic [SLOT_TAG_W-1:0]  s_tag;
    } slot_t;

endpackage

// File: rtl/pspin_dma_rd_desc_arb_if.sv
// Requester-side descriptor/status bundle plus the DMA-side descriptor and
// status channels of the read-descriptor arbiter.
interface pspin_dma_rd_desc_if #(
    parameter int PORTS          = 2,
    parameter int DMA_ADDR_WIDTH = 64,
    parameter int DMA_LEN_WIDTH  = 16,
    parameter int DMA_TAG_WIDTH  = 16,
    parameter int RAM_SEL_WIDTH  = 4,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int S_TAG_WIDTH    = 8
);
    import pspin_dma_pkg::*;

    logic [PORTS-1:0][DMA_ADDR_WIDTH-1:0] s_axis_read_desc_dma_addr;
    logic [PORTS-1:0][RAM_SEL_WIDTH-1:0]  s_axis_read_desc_ram_sel;
    logic [PORTS-1:0][RAM_ADDR_WIDTH-1:0] s_axis_read_desc_ram_addr;
    logic [PORTS-1:0][DMA_LEN_WIDTH-1:0]  s_axis_read_desc_len;
    logic [PORTS-1:0][S_TAG_WIDTH-1:0]    s_axis_read_desc_tag;
    logic [PORTS-1:0]                     s_axis_read_desc_valid;
    logic [PORTS-1:0]                     s_axis_read_desc_ready;

    logic [DMA_ADDR_WIDTH-1:0] m_axis_read_desc_dma_addr;
    logic [RAM_SEL_WIDTH-1:0]  m_axis_read_desc_ram_sel;
    logic [RAM_ADDR_WIDTH-1:0] m_axis_read_desc_ram_addr;
    logic [DMA_LEN_WIDTH-1:0]  m_axis_read_desc_len;
    logic [DMA_TAG_WIDTH-1:0]  m_axis_read_desc_tag;
    logic                      m_axis_read_desc_valid;
    logic                      m_axis_read_desc_ready;

    logic [DMA_TAG_WIDTH-1:0]  s_axis_read_desc_status_tag;
    logic [DMA_ERR_W-1:0]      s_axis_read_desc_status_error;
    logic                      s_axis_read_desc_status_valid;

    logic [PORTS-1:0][S_TAG_WIDTH-1:0] m_axis_read_desc_status_tag;
    logic [PORTS-1:0][DMA_ERR_W-1:0]   m_axis_read_desc_status_error;
    logic [PORTS-1:0]                  m_axis_read_desc_status_valid;

    // Arbiter view.
    modport slave (
        input  s_axis_read_desc_dma_addr, s_axis_read_desc_ram_sel, s_axis_read_desc_ram_addr,
               s_axis_read_desc_len, s_axis_read_desc_tag, s_axis_read_desc_valid,
        output s_axis_read_desc_ready,
        output m_axis_read_desc_dma_addr, m_axis_read_desc_ram_sel, m_axis_read_desc_ram_addr,
               m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
        input  m_axis_read_desc_ready,
        input  s_axis_read_desc_status_tag, s_axis_read_desc_status_error,
               s_axis_read_desc_status_valid,
        output m_axis_read_desc_status_tag, m_axis_read_desc_status_error,
               m_axis_read_desc_status_valid
    );

    // Environment view: requesters plus the DMA engine.
    modport master (
        output s_axis_read_desc_dma_addr, s_axis_read_desc_ram_sel, s_axis_read_desc_ram_addr,
               s_axis_read_desc_len, s_axis_read_desc_tag, s_axis_read_desc_valid,
        input  s_axis_read_desc_ready,
        input  m_axis_read_desc_dma_addr, m_axis_read_desc_ram_sel, m_axis_read_desc_ram_addr,
               m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
        output m_axis_read_desc_ready,
        output s_axis_read_desc_status_tag, s_axis_read_desc_status_error,
               s_axis_read_desc_status_valid,
        input  m_axis_read_desc_status_tag, m_axis_read_desc_status_error,
               m_axis_read_desc_status_valid
    );

endinterface

// File: rtl/pspin_dma_rd_desc_arb_rr_arb.sv
// Round-robin arbiter: first requester at or after the pointer wins; the
// pointer moves past the winner only when the grant is taken.
module pspin_rr_arb #(
    parameter int PORTS = 2,
    localparam int PORT_W = $clog2(PORTS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [PORTS-1:0]  req,
    input  logic              en,
    output logic [PORTS-1:0]  grant,
    output logic [PORT_W-1:0] grant_idx,
    output logic              accept
);

    logic [PORT_W-1:0] ptr;
    logic [PORT_W:0]   sum;
    logic [PORT_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        accept    = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < PORTS; i++) begin
            sum = {1'b0, ptr} + (PORT_W+1)'(i);
            if (sum >= (PORT_W+1)'(PORTS)) sum = sum - (PORT_W+1)'(PORTS);
            idx = sum[PORT_W-1:0];
            if (en && !accept && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                accept     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr <= '0;
        else if (accept)
            ptr <= (grant_idx == PORT_W'(PORTS-1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/pspin_dma_rd_desc_arb.sv
// Shares one DMA read-descriptor channel between PORTS requesters; each
// descriptor carries a slot index as tag so its status can be routed home.
module pspin_dma_rd_desc_arb
    import pspin_dma_pkg::*;
#(
    parameter int PORTS           = 2,
    parameter int DMA_ADDR_WIDTH  = 64,
    parameter int DMA_LEN_WIDTH   = 16,
    parameter int DMA_TAG_WIDTH   = 16,
    parameter int RAM_SEL_WIDTH   = 4,
    parameter int RAM_ADDR_WIDTH  = 16,
    parameter int S_TAG_WIDTH     = 8,
    parameter int MAX_OUTSTANDING = 16,
    localparam int SLOT_W = $clog2(MAX_OUTSTANDING),
    localparam int PORT_W = $clog2(PORTS)
) (
    input  logic              clk,
    input  logic              rstn,
    pspin_dma_rd_desc_if.slave bus,
    output logic [SLOT_W:0]   outstanding,
    output logic              stat_bad_tag
);

    logic [DMA_ADDR_WIDTH-1:0] m_addr_q;
    logic [RAM_SEL_WIDTH-1:0]  m_sel_q;
    logic [RAM_ADDR_WIDTH-1:0] m_raddr_q;
    logic [DMA_LEN_WIDTH-1:0]  m_len_q;
    logic [DMA_TAG_WIDTH-1:0]  m_tag_q;
    logic                      m_valid_q;

    slot_t             slots [MAX_OUTSTANDING];
    logic              has_free;
    logic [SLOT_W-1:0] free_idx;
    logic              en, accept;
    logic [PORTS-1:0]  grant;
    logic [PORT_W-1:0] grant_idx;

    logic [SLOT_W-1:0]      st_idx;
    logic                   upper_zero, st_hit, st_bad;
    logic [PORTS-1:0]       st_valid_q;
    logic [S_TAG_WIDTH-1:0] st_tag_q;
    logic [DMA_ERR_W-1:0]   st_err_q;

    // Lowest-index free slot; the table is read pre-cycle, so a slot freed
    // this cycle is never handed out in the same cycle.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = MAX_OUTSTANDING-1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                has_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign en = rstn && (!m_valid_q || bus.m_axis_read_desc_ready) && has_free;

    pspin_rr_arb #(.PORTS(PORTS)) u_rr_arb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (bus.s_axis_read_desc_valid),
        .en        (en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .accept    (accept)
    );

    assign bus.s_axis_read_desc_ready = grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_sel_q   <= '0;
            m_raddr_q <= '0;
            m_len_q   <= '0;
            m_tag_q   <= '0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_addr_q  <= bus.s_axis_read_desc_dma_addr[grant_idx];
            m_sel_q   <= bus.s_axis_read_desc_ram_sel[grant_idx];
            m_raddr_q <= bus.s_axis_read_desc_ram_addr[grant_idx];
            m_len_q   <= bus.s_axis_read_desc_len[grant_idx];
            m_tag_q   <= DMA_TAG_WIDTH'(free_idx);
        end else if (bus.m_axis_read_desc_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.m_axis_read_desc_dma_addr = m_addr_q;
    assign bus.m_axis_read_desc_ram_sel  = m_sel_q;
    assign bus.m_axis_read_desc_ram_addr = m_raddr_q;
    assign bus.m_axis_read_desc_len      = m_len_q;
    assign bus.m_axis_read_desc_tag      = m_tag_q;
    assign bus.m_axis_read_desc_valid    = m_valid_q;

    assign st_idx = bus.s_axis_read_desc_status_tag[SLOT_W-1:0];
    generate
        if (DMA_TAG_WIDTH > SLOT_W) begin : g_upper
            assign upper_zero = ~|bus.s_axis_read_desc_status_tag[DMA_TAG_WIDTH-1:SLOT_W];
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign st_hit = bus.s_axis_read_desc_status_valid && upper_zero && slots[st_idx].valid;
    assign st_bad = bus.s_axis_read_desc_status_valid && !st_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) slots[i] <= '0;
            outstanding  <= '0;
            stat_bad_tag <= 1'b0;
            st_valid_q   <= '0;
            st_tag_q     <= '0;
            st_err_q     <= '0;
        end else begin
            st_valid_q <= '0;
            if (accept)
                slots[free_idx] <= '{valid: 1'b1,
                                     port:  SLOT_PORT_W'(grant_idx),
                                     s_tag: SLOT_TAG_W'(bus.s_axis_read_desc_tag[grant_idx])};
            if (st_hit) begin
                slots[st_idx].valid <= 1'b0;
                st_valid_q[slots[st_idx].port[PORT_W-1:0]] <= 1'b1;
                st_tag_q <= slots[st_idx].s_tag[S_TAG_WIDTH-1:0];
                st_err_q <= bus.s_axis_read_desc_status_error;
            end
            if (st_bad) stat_bad_tag <= 1'b1;
            outstanding <= outstanding + (SLOT_W+1)'(accept) - (SLOT_W+1)'(st_hit);
        end
    end

    // Tag and error are shared by all ports; only the valid bit is steered.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            bus.m_axis_read_desc_status_tag[p]   = st_tag_q;
            bus.m_axis_read_desc_status_error[p] = st_err_q;
        end
    end
    assign bus.m_axis_read_desc_status_valid = st_valid_q;

endmodule

// File: tb/tb_pspin_dma_rd_desc_arb.sv
// Scoreboard bench for the DMA read-descriptor arbiter: expected descriptors
// and status pulses are queued as stimulus is driven and popped at outputs.
module tb_pspin_dma_rd_desc_arb;

    localparam int PORTS = 2;
    localparam int PW    = 1;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] outstanding;
    logic       stat_bad_tag;

    always #5 clk = ~clk;

    pspin_dma_rd_desc_if #(
        .PORTS(PORTS), .DMA_ADDR_WIDTH(64), .DMA_LEN_WIDTH(16), .DMA_TAG_WIDTH(16),
        .RAM_SEL_WIDTH(4), .RAM_ADDR_WIDTH(16), .S_TAG_WIDTH(8)
    ) bus ();

    pspin_dma_rd_desc_arb #(
        .PORTS(PORTS), .DMA_ADDR_WIDTH(64), .DMA_LEN_WIDTH(16), .DMA_TAG_WIDTH(16),
        .RAM_SEL_WIDTH(4), .RAM_ADDR_WIDTH(16), .S_TAG_WIDTH(8), .MAX_OUTSTANDING(16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus.slave),
        .outstanding  (outstanding),
        .stat_bad_tag (stat_bad_tag)
    );

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  sel;
        logic [15:0] raddr;
        logic [15:0] len;
        logic [15:0] tag;
    } desc_t;

    typedef struct {
        logic [PW-1:0] port;
        logic [7:0]    tag;
        logic [3:0]    err;
    } st_t;

    desc_t desc_q[$];
    st_t   st_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic desc_t exp_desc(logic [PW-1:0] p, logic [7:0] stag, int slot);
        desc_t d;
        d.addr  = {16'hC0DE, 7'h0, p, stag, 32'h0000_1000};
        d.sel   = stag[3:0];
        d.raddr = {7'h0, p, stag};
        d.len   = {8'h01, stag};
        d.tag   = 16'(slot);
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(logic [PW-1:0] p, logic [7:0] stag);
        desc_t d;
        d = exp_desc(p, stag, 0);
        bus.s_axis_read_desc_dma_addr[p] = d.addr;
        bus.s_axis_read_desc_ram_sel[p]  = d.sel;
        bus.s_axis_read_desc_ram_addr[p] = d.raddr;
        bus.s_axis_read_desc_len[p]      = d.len;
        bus.s_axis_read_desc_tag[p]      = stag;
        bus.s_axis_read_desc_valid[p]    = 1'b1;
    endtask

    task automatic set_status(logic [15:0] tag, logic [3:0] err, logic vld);
        bus.s_axis_read_desc_status_tag   = tag;
        bus.s_axis_read_desc_status_error = err;
        bus.s_axis_read_desc_status_valid = vld;
    endtask

    task automatic clear_inputs;
        bus.s_axis_read_desc_dma_addr = '0;
        bus.s_axis_read_desc_ram_sel  = '0;
        bus.s_axis_read_desc_ram_addr = '0;
        bus.s_axis_read_desc_len      = '0;
        bus.s_axis_read_desc_tag      = '0;
        bus.s_axis_read_desc_valid    = '0;
        bus.m_axis_read_desc_ready    = 1'b0;
        set_status(16'h0, 4'h0, 1'b0);
    endtask

    task automatic apply_reset;
        rstn = 1'b0;
        clear_inputs();
        desc_q.delete();
        st_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Output monitor: handshakes and status pulses are popped against the queues.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.m_axis_read_desc_valid && bus.m_axis_read_desc_ready) begin
                checks++;
                if (desc_q.size() == 0) begin
                    errors++;
                    $display("FAIL desc_unexpected: got tag=%h addr=%h, no descriptor expected",
                             bus.m_axis_read_desc_tag, bus.m_axis_read_desc_dma_addr);
                end else begin
                    desc_t e;
                    e = desc_q.pop_front();
                    if (bus.m_axis_read_desc_tag !== e.tag || bus.m_axis_read_desc_dma_addr !== e.addr ||
                        bus.m_axis_read_desc_ram_sel !== e.sel || bus.m_axis_read_desc_ram_addr !== e.raddr ||
                        bus.m_axis_read_desc_len !== e.len) begin
                        errors++;
                        $display("FAIL desc: got tag=%h addr=%h sel=%h raddr=%h len=%h, exp tag=%h addr=%h sel=%h raddr=%h len=%h",
                                 bus.m_axis_read_desc_tag, bus.m_axis_read_desc_dma_addr,
                                 bus.m_axis_read_desc_ram_sel, bus.m_axis_read_desc_ram_addr,
                                 bus.m_axis_read_desc_len, e.tag, e.addr, e.sel, e.raddr, e.len);
                    end
                end
            end
            if (|bus.m_axis_read_desc_status_valid) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL status_unexpected: got valid=%b, no status expected",
                             bus.m_axis_read_desc_status_valid);
                end else begin
                    st_t e;
                    logic [PORTS-1:0] oh;
                    e  = st_q.pop_front();
                    oh = '0;
                    oh[e.port] = 1'b1;
                    if (bus.m_axis_read_desc_status_valid !== oh ||
                        bus.m_axis_read_desc_status_tag[e.port] !== e.tag ||
                        bus.m_axis_read_desc_status_error[e.port] !== e.err) begin
                        errors++;
                        $display("FAIL status: got valid=%b tag=%h err=%h, exp valid=%b tag=%h err=%h",
                                 bus.m_axis_read_desc_status_valid, bus.m_axis_read_desc_status_tag[e.port],
                                 bus.m_axis_read_desc_status_error[e.port], oh, e.tag, e.err);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rstn = 1'b0;
        clear_inputs();
        set_req(1'b0, 8'h01);
        set_req(1'b1, 8'h02);
        bus.m_axis_read_desc_ready = 1'b1;
        set_status(16'h0, 4'h0, 1'b1);
        tick();
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b00 || bus.m_axis_read_desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%b m_valid=%b, exp 00/0",
                     bus.s_axis_read_desc_ready, bus.m_axis_read_desc_valid);
        end
        clear_inputs();
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if (outstanding !== 5'd0 || stat_bad_tag !== 1'b0 || bus.m_axis_read_desc_status_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_state: got outstanding=%0d bad=%b st_valid=%b, exp 0/0/00",
                     outstanding, stat_bad_tag, bus.m_axis_read_desc_status_valid);
        end
    endtask

    task automatic test_single;
        apply_reset();
        bus.m_axis_read_desc_ready = 1'b1;
        set_req(1'b0, 8'h5A);
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready: got %b, exp 01", bus.s_axis_read_desc_ready);
        end
        desc_q.push_back(exp_desc(1'b0, 8'h5A, 0));
        tick();
        bus.s_axis_read_desc_valid = '0;
        checks++;
        if (bus.m_axis_read_desc_valid !== 1'b1 || bus.m_axis_read_desc_tag !== 16'h0) begin
            errors++;
            $display("FAIL single_latency: got m_valid=%b tag=%h, exp 1/0000",
                     bus.m_axis_read_desc_valid, bus.m_axis_read_desc_tag);
        end
        tick();
        set_status(16'h0000, 4'h0, 1'b1);
        st_q.push_back('{port: 1'b0, tag: 8'h5A, err: 4'h0});
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        checks++;
        if (bus.m_axis_read_desc_status_valid !== 2'b01) begin
            errors++;
            $display("FAIL single_status_pulse: got %b, exp 01", bus.m_axis_read_desc_status_valid);
        end
        tick();
        checks++;
        if (bus.m_axis_read_desc_status_valid !== 2'b00 || outstanding !== 5'd0) begin
            errors++;
            $display("FAIL single_after: got st_valid=%b outstanding=%0d, exp 00/0",
                     bus.m_axis_read_desc_status_valid, outstanding);
        end
        checks++;
        if (desc_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: got %0d desc %0d status pending, exp 0/0", desc_q.size(), st_q.size());
        end
    endtask

    task automatic test_alternate;
        logic [7:0] stag [2];
        stag[0] = 8'hA0;
        stag[1] = 8'hB1;
        apply_reset();
        bus.m_axis_read_desc_ready = 1'b1;
        set_req(1'b0, stag[0]);
        set_req(1'b1, stag[1]);
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.s_axis_read_desc_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got %b, exp %b", k, bus.s_axis_read_desc_ready,
                         (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            desc_q.push_back(exp_desc(PW'(k % 2), stag[k % 2], k));
            tick();
        end
        bus.s_axis_read_desc_valid = '0;
        tick();
        checks++;
        if (outstanding !== 5'd4) begin
            errors++;
            $display("FAIL alt_outstanding: got %0d, exp 4", outstanding);
        end
        set_status(16'h0002, 4'h5, 1'b1);
        st_q.push_back('{port: 1'b0, tag: stag[0], err: 4'h5});
        tick();
        set_status(16'h0001, 4'hC, 1'b1);
        st_q.push_back('{port: 1'b1, tag: stag[1], err: 4'hC});
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        tick();
        tick();
        checks++;
        if (outstanding !== 5'd2 || desc_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL alt_drain: got outstanding=%0d pending=%0d/%0d, exp 2/0/0",
                     outstanding, desc_q.size(), st_q.size());
        end
    endtask

    task automatic test_full;
        apply_reset();
        bus.m_axis_read_desc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_req(1'b0, 8'(i));
            #1;
            checks++;
            if (bus.s_axis_read_desc_ready !== 2'b01) begin
                errors++;
                $display("FAIL full_fill_ready[%0d]: got %b, exp 01", i, bus.s_axis_read_desc_ready);
            end
            desc_q.push_back(exp_desc(1'b0, 8'(i), i));
            tick();
        end
        set_req(1'b0, 8'h77);
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b00 || outstanding !== 5'd16) begin
            errors++;
            $display("FAIL full_block: got ready=%b outstanding=%0d, exp 00/16",
                     bus.s_axis_read_desc_ready, outstanding);
        end
        tick();
        tick();
        set_status(16'h0007, 4'h0, 1'b1);
        st_q.push_back('{port: 1'b0, tag: 8'h07, err: 4'h0});
        desc_q.push_back(exp_desc(1'b0, 8'h77, 7));
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b00) begin
            errors++;
            $display("FAIL full_same_cycle_ready: got %b, exp 00", bus.s_axis_read_desc_ready);
        end
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b01) begin
            errors++;
            $display("FAIL full_next_cycle_ready: got %b, exp 01", bus.s_axis_read_desc_ready);
        end
        tick();
        bus.s_axis_read_desc_valid = '0;
        checks++;
        if (outstanding !== 5'd16) begin
            errors++;
            $display("FAIL full_refill: got outstanding=%0d, exp 16", outstanding);
        end
        tick();
        tick();
        checks++;
        if (desc_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL full_drain: got %0d desc %0d status pending, exp 0/0", desc_q.size(), st_q.size());
        end
    endtask

    task automatic test_backpressure;
        desc_t held;
        held = exp_desc(1'b0, 8'h11, 0);
        apply_reset();
        set_req(1'b0, 8'h11);
        set_req(1'b1, 8'h22);
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_first_ready: got %b, exp 01", bus.s_axis_read_desc_ready);
        end
        desc_q.push_back(held);
        tick();
        set_req(1'b0, 8'h13);
        #1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.s_axis_read_desc_ready !== 2'b00 || bus.m_axis_read_desc_valid !== 1'b1 ||
                bus.m_axis_read_desc_tag !== 16'h0 || bus.m_axis_read_desc_dma_addr !== held.addr ||
                outstanding !== 5'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ready=%b m_valid=%b tag=%h addr=%h out=%0d, exp 00/1/0000/%h/1",
                         c, bus.s_axis_read_desc_ready, bus.m_axis_read_desc_valid,
                         bus.m_axis_read_desc_tag, bus.m_axis_read_desc_dma_addr, outstanding, held.addr);
            end
            tick();
        end
        bus.m_axis_read_desc_ready = 1'b1;
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, exp 10", bus.s_axis_read_desc_ready);
        end
        desc_q.push_back(exp_desc(1'b1, 8'h22, 1));
        tick();
        checks++;
        if (bus.m_axis_read_desc_valid !== 1'b1 || bus.s_axis_read_desc_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_stream: got m_valid=%b ready=%b, exp 1/01",
                     bus.m_axis_read_desc_valid, bus.s_axis_read_desc_ready);
        end
        desc_q.push_back(exp_desc(1'b0, 8'h13, 2));
        tick();
        bus.s_axis_read_desc_valid = '0;
        checks++;
        if (bus.m_axis_read_desc_valid !== 1'b1 || bus.m_axis_read_desc_tag !== 16'h2) begin
            errors++;
            $display("FAIL bp_third: got m_valid=%b tag=%h, exp 1/0002",
                     bus.m_axis_read_desc_valid, bus.m_axis_read_desc_tag);
        end
        tick();
        tick();
        checks++;
        if (bus.m_axis_read_desc_valid !== 1'b0 || desc_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got m_valid=%b pending=%0d, exp 0/0", bus.m_axis_read_desc_valid, desc_q.size());
        end
    endtask

    task automatic test_bad_tag;
        apply_reset();
        set_status(16'h0003, 4'h0, 1'b1);
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        checks++;
        if (stat_bad_tag !== 1'b1 || outstanding !== 5'd0) begin
            errors++;
            $display("FAIL bad_empty_slot: got bad=%b outstanding=%0d, exp 1/0", stat_bad_tag, outstanding);
        end
        tick();
        tick();
        checks++;
        if (stat_bad_tag !== 1'b1) begin
            errors++;
            $display("FAIL bad_sticky: got %b, exp 1", stat_bad_tag);
        end
        apply_reset();
        checks++;
        if (stat_bad_tag !== 1'b0) begin
            errors++;
            $display("FAIL bad_cleared: got %b, exp 0", stat_bad_tag);
        end
        bus.m_axis_read_desc_ready = 1'b1;
        set_req(1'b0, 8'h3C);
        desc_q.push_back(exp_desc(1'b0, 8'h3C, 0));
        tick();
        bus.s_axis_read_desc_valid = '0;
        tick();
        set_status(16'h0100, 4'h0, 1'b1);
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        checks++;
        if (stat_bad_tag !== 1'b1 || outstanding !== 5'd1) begin
            errors++;
            $display("FAIL bad_upper_bits: got bad=%b outstanding=%0d, exp 1/1", stat_bad_tag, outstanding);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        set_status(16'h0000, 4'h0, 1'b1);
        tick();
        set_status(16'h0000, 4'h0, 1'b0);
        tick();
        checks++;
        if (stat_bad_tag !== 1'b1 || outstanding !== 5'd0) begin
            errors++;
            $display("FAIL bad_after_reset: got bad=%b outstanding=%0d, exp 1/0", stat_bad_tag, outstanding);
        end
        checks++;
        if (desc_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL bad_drain: got %0d desc %0d status pending, exp 0/0", desc_q.size(), st_q.size());
        end
    endtask

    task automatic test_same_cycle;
        apply_reset();
        bus.m_axis_read_desc_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_req(1'b0, 8'(8'h40 + i));
            desc_q.push_back(exp_desc(1'b0, 8'(8'h40 + i), i));
            tick();
        end
        bus.s_axis_read_desc_valid = '0;
        set_req(1'b1, 8'hAB);
        set_status(16'h0004, 4'h2, 1'b1);
        desc_q.push_back(exp_desc(1'b1, 8'hAB, 15));
        st_q.push_back('{port: 1'b0, tag: 8'h44, err: 4'h2});
        #1;
        checks++;
        if (bus.s_axis_read_desc_ready !== 2'b10 || outstanding !== 5'd15) begin
            errors++;
            $display("FAIL same_setup: got ready=%b outstanding=%0d, exp 10/15",
                     bus.s_axis_read_desc_ready, outstanding);
        end
        tick();
        bus.s_axis_read_desc_valid = '0;
        set_status(16'h0000, 4'h0, 1'b0);
        checks++;
        if (outstanding !== 5'd15) begin
            errors++;
            $display("FAIL same_outstanding: got %0d, exp 15", outstanding);
        end
        tick();
        tick();
        checks++;
        if (outstanding !== 5'd15 || desc_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL same_drain: got outstanding=%0d pending=%0d/%0d, exp 15/0/0",
                     outstanding, desc_q.size(), st_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_backpressure();
        test_bad_tag();
        test_same_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
